// File: rtl/nibble_logic_sequencer_if.sv
// -----------------------------------------------------------------------------
// nibble_logic_sequencer_if
// Groups the request/response bus of the nibble logic sequencer.
//   master : requester side. Drives start_valid/op/x/b and done_ready.
//   slave  : sequencer side. Drives start_ready/result/done_valid/busy/zero.
// Signals:
//   start_valid / start_ready : request handshake
//   op                        : 00 AND, 01 OR, 10 XOR, 11 XNOR
//   x, b                      : DATA_W-bit operands
//   result                    : DATA_W-bit assembled result
//   done_valid / done_ready   : result handshake
//   busy                      : high while nibbles are being processed
//   zero                      : result==0 flag (optional feature)
// -----------------------------------------------------------------------------
interface nibble_logic_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start_valid;
    logic              start_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
    logic              done_valid;
    logic              done_ready;
    logic              busy;
    logic              zero;

    modport master (
        output start_valid, op, x, b, done_ready,
        input  start_ready, result, done_valid, busy, zero
    );

    modport slave (
        input  start_valid, op, x, b, done_ready,
        output start_ready, result, done_valid, busy, zero
    );
endinterface

// File: rtl/nibble_logic_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_logic_sequencer
// Time-shares one SLICE_W-bit AND/OR/XOR/XNOR slice across all nibbles of
// DATA_W-bit operands. A request is accepted in IDLE, one nibble per clock is
// computed LSB first in RUN, and the assembled result is offered in DONE until
// the consumer takes it.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous reset, active low; aborts any run, result cleared
//   bus   : nibble_logic_sequencer_if.slave (request/result handshakes,
//           busy, zero)
// Configuration:
//   NIBBLE_SEQ_ZERO_FLAG_EN : when defined, zero is a registered flag set on
//   DONE entry to (final result==0), cleared on reset and on entry to IDLE.
//   When undefined, zero is tied to 0.
// -----------------------------------------------------------------------------
module nibble_logic_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    nibble_logic_sequencer_if.slave bus
);
    localparam int STEPS = DATA_W / SLICE_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] result_r;
    logic [DATA_W-1:0] result_next_s;
    logic              last_step_s;

    // The shared logic slice.
    function automatic logic [SLICE_W-1:0] slice_f(
        input logic [1:0]         o,
        input logic [SLICE_W-1:0] a,
        input logic [SLICE_W-1:0] c
    );
        logic [SLICE_W-1:0] r;
        case (o)
            2'b00:   r = a & c;
            2'b01:   r = a | c;
            2'b10:   r = a ^ c;
            2'b11:   r = ~(a ^ c);
            default: r = {SLICE_W{1'b0}};
        endcase
        return r;
    endfunction

    // Result with the nibble selected by cnt replaced by the slice output.
    always_comb begin
        result_next_s = result_r;
        for (int k = 0; k < STEPS; k++) begin
            if (cnt_r == CNT_W'(k)) begin
                result_next_s[k*SLICE_W +: SLICE_W] =
                    slice_f(op_r, x_r[k*SLICE_W +: SLICE_W], b_r[k*SLICE_W +: SLICE_W]);
            end else begin
                result_next_s[k*SLICE_W +: SLICE_W] = result_r[k*SLICE_W +: SLICE_W];
            end
        end
    end

    assign last_step_s = (cnt_r == LAST_CNT);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, nibble counter and result accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 2'b00;
            x_r      <= {DATA_W{1'b0}};
            b_r      <= {DATA_W{1'b0}};
            result_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_valid) begin
                        op_r     <= bus.op;
                        x_r      <= bus.x;
                        b_r      <= bus.b;
                        result_r <= {DATA_W{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    result_r <= result_next_s;
                    // Counter returns to 0 on the last nibble so it never wraps.
                    if (last_step_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
    logic zero_r;

    // Zero flag: evaluated on the final nibble write, cleared when leaving DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
        end else if ((state_r == RUN) && last_step_s) begin
            zero_r <= (result_next_s == {DATA_W{1'b0}});
        end else if ((state_r == DONE) && bus.done_ready) begin
            zero_r <= 1'b0;
        end
    end

    assign bus.zero = zero_r;
`else
    assign bus.zero = 1'b0;
`endif

    assign bus.start_ready = (state_r == IDLE);
    assign bus.busy        = (state_r == RUN);
    assign bus.done_valid  = (state_r == DONE);
    assign bus.result      = result_r;
endmodule
